// File: rtl/alu_sequencer_if.sv
// Instruction handshake between an instruction source and the ALU sequencer.
// The source holds the instruction fields stable while InValid is high and InReady is low.
interface alu_sequencer_if;
    logic       InValid;
    logic       InReady;
    logic [3:0] InOp;
    logic [1:0] InRd;
    logic [1:0] InRs1;
    logic [1:0] InRs2;
    logic [7:0] InImm;

    modport master (output InValid, InOp, InRd, InRs1, InRs2, InImm, input InReady);
    modport slave  (input InValid, InOp, InRd, InRs1, InRs2, InImm, output InReady);
endinterface

// File: rtl/alu_sequencer.sv
// Sequences one instruction at a time through an external combinational ALU:
// IDLE -> READ -> EXEC -> WRITE, with a 4-entry register file and sticky Z/N/C flags.
module alu_sequencer #(
    parameter int NREGS = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    alu_sequencer_if.slave   in_if,
    output logic [WIDTH-1:0] AluOperand1,
    output logic [WIDTH-1:0] AluOperand2,
    output logic [3:0]       AluMode,
    input  logic [WIDTH-1:0] AluOut,
    output logic             Done,
    output logic             Err,
    output logic             FlagZ,
    output logic             FlagN,
    output logic             FlagC,
    input  logic [1:0]       DbgAddr,
    output logic [WIDTH-1:0] DbgData
);
    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_NOT   = 4'd4;
    localparam logic [3:0] OP_LOADI = 4'd5;

    typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] regs_q [NREGS];
    logic [3:0]       op_q;
    logic [1:0]       rd_q, rs1_q, rs2_q;
    logic [WIDTH-1:0] imm_q, result_q, opnd1_q, opnd2_q;
    logic [3:0]       mode_q;
    logic             ready_q, done_q, err_q;
    logic             flag_z_q, flag_n_q, flag_c_q;

    logic             is_alu, is_loadi, is_legal;
    logic [WIDTH:0]   sum;
    logic             carry_d;

    assign is_alu   = (op_q <= OP_NOT);
    assign is_loadi = (op_q == OP_LOADI);
    assign is_legal = (op_q <= OP_LOADI);
    assign sum      = {1'b0, opnd1_q} + {1'b0, opnd2_q};

    // Operand registers hold their EXEC values through WRITE, so the carry is taken from them.
    always_comb begin
        carry_d = 1'b0;
        case (op_q)
            OP_ADD:  carry_d = sum[WIDTH];
            OP_SUB:  carry_d = (opnd1_q < opnd2_q);
            default: carry_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            imm_q    <= '0;
            result_q <= '0;
            opnd1_q  <= '0;
            opnd2_q  <= '0;
            mode_q   <= '0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_if.InValid && ready_q) begin
                        op_q    <= in_if.InOp;
                        rd_q    <= in_if.InRd;
                        rs1_q   <= in_if.InRs1;
                        rs2_q   <= in_if.InRs2;
                        imm_q   <= in_if.InImm;
                        ready_q <= 1'b0;
                        state_q <= READ;
                    end
                end
                READ: begin
                    opnd1_q <= is_alu ? regs_q[rs1_q] : '0;
                    opnd2_q <= is_alu ? regs_q[rs2_q] : '0;
                    mode_q  <= is_alu ? op_q : 4'd0;
                    state_q <= EXEC;
                end
                EXEC: begin
                    result_q <= is_loadi ? imm_q : AluOut;
                    done_q   <= 1'b1;
                    err_q    <= !is_legal;
                    state_q  <= WRITE;
                end
                WRITE: begin
                    if (is_legal) regs_q[rd_q] <= result_q;
                    if (is_alu) begin
                        flag_z_q <= (result_q == '0);
                        flag_n_q <= result_q[WIDTH-1];
                        flag_c_q <= carry_d;
                    end
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_if.InReady = ready_q;
    assign AluOperand1   = opnd1_q;
    assign AluOperand2   = opnd2_q;
    assign AluMode       = mode_q;
    assign Done          = done_q;
    assign Err           = err_q;
    assign FlagZ         = flag_z_q;
    assign FlagN         = flag_n_q;
    assign FlagC         = flag_c_q;
    assign DbgData       = regs_q[DbgAddr];
endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: directed program plus random instructions,
// expected results from an arithmetic reference model, checked by an independent monitor.
module tb_alu_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] AluOperand1, AluOperand2, AluOut, DbgData;
    logic [3:0] AluMode;
    logic       Done, Err, FlagZ, FlagN, FlagC;
    logic [1:0] DbgAddr;

    alu_sequencer_if in_if();

    alu_sequencer #(.NREGS(4), .WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_if(in_if),
        .AluOperand1(AluOperand1), .AluOperand2(AluOperand2), .AluMode(AluMode),
        .AluOut(AluOut), .Done(Done), .Err(Err),
        .FlagZ(FlagZ), .FlagN(FlagN), .FlagC(FlagC),
        .DbgAddr(DbgAddr), .DbgData(DbgData)
    );

    always #5 clk = ~clk;

    // External combinational ALU
    always_comb begin
        case (AluMode)
            4'd0:    AluOut = AluOperand1 + AluOperand2;
            4'd1:    AluOut = AluOperand1 - AluOperand2;
            4'd2:    AluOut = AluOperand1 & AluOperand2;
            4'd3:    AluOut = AluOperand1 | AluOperand2;
            4'd4:    AluOut = ~AluOperand1;
            default: AluOut = 8'd0;
        endcase
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         acc;
        logic       err;
        logic [1:0] rd;
        logic [7:0] oldv;
        logic [7:0] newv;
        logic [3:0] mode;
        logic       z, n, c;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   last_acc = -100;
    logic [7:0] m [4];
    logic fz, fn, fc;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) m[i] = 8'd0;
        fz = 1'b0; fn = 1'b0; fc = 1'b0;
    endfunction

    function automatic exp_t model(logic [3:0] op, logic [1:0] rd, logic [1:0] rs1,
                                   logic [1:0] rs2, logic [7:0] imm);
        exp_t e;
        int   a, b, r, c;
        a = int'(m[rs1]);
        b = int'(m[rs2]);
        r = 0; c = 0;
        e.acc  = cyc;
        e.rd   = rd;
        e.oldv = m[rd];
        e.err  = (op > 4'd5);
        e.mode = (op <= 4'd4) ? op : 4'd0;
        case (op)
            4'd0: begin r = (a + b) % 256; c = (a + b >= 256) ? 1 : 0; end
            4'd1: begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = 255 - a;
            4'd5: r = int'(imm);
            default: r = 0;
        endcase
        if (op <= 4'd5) m[rd] = 8'(r);
        if (op <= 4'd4) begin
            fz = (r == 0);
            fn = (r >= 128);
            fc = (c != 0);
        end
        e.newv = m[rd];
        e.z = fz; e.n = fn; e.c = fc;
        return e;
    endfunction

    // Presents an instruction and returns one cycle after acceptance with InValid still high.
    task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, input logic [7:0] imm);
        int w;
        w = 0;
        in_if.InOp = op; in_if.InRd = rd; in_if.InRs1 = rs1; in_if.InRs2 = rs2; in_if.InImm = imm;
        in_if.InValid = 1'b1;
        while (!in_if.InReady && w < 12) begin
            @(negedge clk);
            w++;
        end
        if (!in_if.InReady) begin
            chk("accept_timeout", 32'd0, 32'd1);
            in_if.InValid = 1'b0;
            return;
        end
        q.push_back(model(op, rd, rs1, rs2, imm));
        last_acc = cyc;
        @(negedge clk);
    endtask

    // Monitor: latency, busy InReady, EXEC mode, Err/Done, pre/post write values and flags.
    initial begin
        exp_t cur;
        bit   post;
        post = 1'b0;
        DbgAddr = 2'd0;
        forever begin
            @(negedge clk);
            if (post) begin
                post = 1'b0;
                chk("rf_after_write", DbgData, cur.newv);
                chk("flags_zcn", {FlagZ, FlagN, FlagC}, {cur.z, cur.n, cur.c});
                chk("done_one_cycle", Done, 1'b0);
            end
            if (cyc > last_acc && cyc <= last_acc + 3)
                chk("busy_inready", in_if.InReady, 1'b0);
            if (q.size() > 0 && cyc == q[0].acc + 2)
                chk("exec_alumode", AluMode, q[0].mode);
            if (Err && !Done) chk("err_without_done", 1'b1, 1'b0);
            if (Done) begin
                if (q.size() == 0) begin
                    chk("spurious_done", 1'b1, 1'b0);
                end else begin
                    cur = q.pop_front();
                    chk("done_latency", 32'(cyc - cur.acc), 32'd3);
                    chk("err", Err, cur.err);
                    DbgAddr = cur.rd;
                    #1;
                    chk("rf_before_write", DbgData, cur.oldv);
                    post = 1'b1;
                end
            end
        end
    end

    initial begin
        int w;
        logic [3:0] op;
        in_if.InValid = 1'b0;
        in_if.InOp = 4'd0; in_if.InRd = 2'd0; in_if.InRs1 = 2'd0; in_if.InRs2 = 2'd0; in_if.InImm = 8'd0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_inready", in_if.InReady, 1'b1);
        chk("reset_done_err", {Done, Err}, 2'b00);
        chk("reset_flags", {FlagZ, FlagN, FlagC}, 3'b000);
        chk("reset_alu_drive", {AluOperand1, AluOperand2, AluMode}, 20'd0);

        issue(4'd5, 2'd1, 2'd0, 2'd0, 8'hF0);
        issue(4'd5, 2'd2, 2'd0, 2'd0, 8'h20);
        issue(4'd0, 2'd3, 2'd1, 2'd2, 8'h00);
        issue(4'd1, 2'd0, 2'd2, 2'd1, 8'h00);
        issue(4'd1, 2'd0, 2'd1, 2'd1, 8'h00);
        issue(4'd4, 2'd1, 2'd1, 2'd0, 8'h00);
        issue(4'd5, 2'd2, 2'd0, 2'd0, 8'hAA);
        issue(4'd5, 2'd3, 2'd0, 2'd0, 8'h55);
        issue(4'd2, 2'd0, 2'd2, 2'd3, 8'h00);
        issue(4'd3, 2'd1, 2'd2, 2'd3, 8'h00);
        issue(4'd2, 2'd0, 2'd2, 2'd3, 8'h00);
        issue(4'd10, 2'd2, 2'd1, 2'd3, 8'h77);

        // Abort an ADD in EXEC; the register file and flags must come back clean.
        issue(4'd5, 2'd1, 2'd0, 2'd0, 8'h11);
        issue(4'd5, 2'd2, 2'd0, 2'd0, 8'h22);
        issue(4'd0, 2'd3, 2'd1, 2'd2, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        in_if.InValid = 1'b0;
        q.delete();
        last_acc = -100;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        chk("abort_inready", in_if.InReady, 1'b1);
        chk("abort_done", Done, 1'b0);
        chk("abort_flags", {FlagZ, FlagN, FlagC}, 3'b000);
        chk("abort_alumode", AluMode, 4'd0);
        issue(4'd0, 2'd0, 2'd3, 2'd1, 8'h00);
        issue(4'd3, 2'd1, 2'd3, 2'd2, 8'h00);

        for (int i = 0; i < 200; i++) begin
            op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 5));
            issue(op, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
            w = $urandom_range(0, 2);
            if (w > 0) begin
                in_if.InValid = 1'b0;
                repeat (w) @(negedge clk);
            end
        end
        in_if.InValid = 1'b0;

        w = 0;
        while (q.size() != 0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        repeat (2) @(negedge clk);
        chk("drain", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Controller that sequences the 8-bit ALU datapath (ADD/SUB/AND/OR/NOT).
- Accepts one instruction at a time over a valid/ready handshake.
- For each instruction it reads operands from a 4-entry x 8-bit register file, drives the external combinational ALU, computes Z/N/C flags, and writes the result back.
- Sits between the instruction source and the ALU instance.

Parameters:
- NREGS, 4, register-file depth; fixed at 4 because register index fields are 2 bits.
- WIDTH, 8, datapath width; must match the ALU operand width.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- InValid  input  1  instruction present.
- InReady  output  1  sequencer can accept an instruction.
- InOp  input  4  opcode: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 NOT, 0101 LOADI; all others illegal.
- InRd  input  2  destination register.
- InRs1  input  2  source 1.
- InRs2  input  2  source 2; ignored by NOT and LOADI.
- InImm  input  8  immediate for LOADI.
- AluOperand1  output  8  drives ALU Operand1.
- AluOperand2  output  8  drives ALU Operand2.
- AluMode  output  4  drives ALU Mode.
- AluOut  input  8  ALU result, combinational from the three outputs above.
- Done  output  1  one-cycle pulse on instruction retirement.
- Err  output  1  one-cycle pulse coincident with Done for an illegal opcode.
- FlagZ / FlagN / FlagC  output  1 each  sticky status flags.
- DbgAddr  input  2  register-file debug read address.
- DbgData  output  8  combinational read of reg[DbgAddr].

Behaviour:
- Reset (synchronous, active-high, rst sampled high on a rising edge):
  - state to IDLE; all 4 registers to 0; flags to 0.
  - InReady=1 after reset; Done=0, Err=0.
  - AluOperand1/AluOperand2/AluMode = 0.
- Reset has priority over everything. Reset mid-instruction aborts it: no writeback, no Done.
- FSM states: IDLE -> READ -> EXEC -> WRITE -> IDLE.
  - IDLE: InReady=1. On InValid&&InReady at edge T, latch InOp/InRd/InRs1/InRs2/InImm; go to READ.
  - READ (T+1): latch op1=reg[Rs1], op2=reg[Rs2] into operand registers; go to EXEC.
  - EXEC (T+2): AluOperand1/2 and AluMode are registered outputs, valid for this whole cycle. AluMode = latched opcode for legal ALU ops, 0000 otherwise. Capture AluOut into the result register at the end of the cycle; go to WRITE.
  - WRITE (T+3): write reg[Rd] (legal ops only); update flags; Done=1 (plus Err for illegal ops); go to IDLE.
- InReady is 1 only in IDLE and 0 in READ/EXEC/WRITE. Throughput is one instruction per 4 cycles; Done occurs 3 cycles after acceptance.
- InValid while InReady=0 is ignored; the source must hold the instruction until accepted.
- LOADI: result = InImm; ALU not used (AluMode=0000 with operands driven as 0); flags unchanged.
- Illegal opcode (0110-1111): no register write, flags unchanged, Err=1 with Done.
- Flags on ADD/SUB/AND/OR/NOT, computed from captured operands and result:
  - Z = (result==0); N = result[7].
  - ADD: C = bit 8 of the 9-bit sum op1+op2.
  - SUB: C = borrow = (op1 < op2) unsigned.
  - AND/OR/NOT: C = 0.
- Result wraps modulo 256 (matches ALU).
- Hazards:
  - Rs1/Rs2 equal to Rd: reads occur in READ, before the write, so old values are used. No bypass is needed, since instructions never overlap.
  - DbgData during WRITE shows the pre-write value; the new value is visible the cycle after.
- Done and Err are never high outside WRITE.

Test Plan:
- Reset, then LOADI r1=0xF0, LOADI r2=0x20, ADD r3=r1+r2 -> r3=0x10, C=1, Z=0, N=0. Done exactly 3 cycles after each acceptance; InReady low for 3 cycles each time.
- SUB r0=r2-r1 (0x20-0xF0) -> r0=0x30, C=1; then SUB r0=r1-r1 -> r0=0x00, Z=1, C=0, N=0.
- NOT r1=~r1 with r1=0xF0 -> 0x0F; also check AND/OR with 0xAA/0x55 -> 0x00 (Z=1) / 0xFF (N=1), C=0.
- Illegal opcode 1010 with prior flags Z=1 -> Err and Done pulse together; no register changes; flags unchanged.
- Assert rst in EXEC of ADD r3 -> no Done; r3=0; state IDLE; InReady=1 the next cycle. Hold InValid high during busy cycles -> instruction accepted only once IDLE is reached.
